// File: rtl/ultrasonic_pkg.sv
// ultrasonic_pkg: shared types and constants for the ultrasonic scheduler.
// Holds the FSM state enum, sensor count, tick counter width and default timing.
package ultrasonic_pkg;
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;
    localparam int NUM_SENSORS       = 3;
    localparam int CNT_W             = 16;
    localparam int DEF_CLK_DIV       = 50;
    localparam int DEF_TRIG_TICKS    = 10;
    localparam int DEF_TIMEOUT_TICKS = 30000;
    localparam int DEF_GAP_TICKS     = 10000;
    localparam int DEF_THRESH_TICKS  = 1160;
endpackage

// File: rtl/us_tick_gen.sv
// us_tick_gen: CLK_DIV prescaler producing a one-cycle tick strobe.
// Ports: fpgaclk (clock), rst (sync active-high), restart (zero the prescaler
// so the next tick lands exactly CLK_DIV cycles later), tick (strobe output).
module us_tick_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic fpgaclk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
    logic [DW-1:0] div;
    assign tick = (div == LAST);
    always_ff @(posedge fpgaclk)
        if (rst || restart) div <= '0;
        else div <= tick ? '0 : div + 1'b1;
endmodule

// File: rtl/ultrasonic_scheduler.sv
// ultrasonic_scheduler: round-robin trigger/echo timing engine for 3 ultrasonic sensors.
// Ports: fpgaclk, rst (sync active-high), en (scan enable), echo[2:0] (async echoes),
// trigger[2:0] (trigger pulses), led[2:0] (obstacle flags), dist_us (3x16-bit widths),
// meas_valid/meas_idx/meas_timeout (one-cycle completion report).
import ultrasonic_pkg::*;

module ultrasonic_scheduler #(
    parameter int CLK_DIV       = DEF_CLK_DIV,
    parameter int TRIG_TICKS    = DEF_TRIG_TICKS,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    parameter int GAP_TICKS     = DEF_GAP_TICKS,
    parameter int THRESH_TICKS  = DEF_THRESH_TICKS
) (
    input  logic                         fpgaclk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NUM_SENSORS-1:0]       echo,
    output logic [NUM_SENSORS-1:0]       trigger,
    output logic [NUM_SENSORS-1:0]       led,
    output logic [NUM_SENSORS*CNT_W-1:0] dist_us,
    output logic                         meas_valid,
    output logic [1:0]                   meas_idx,
    output logic                         meas_timeout
);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_TICKS - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] THRESH    = CNT_W'(THRESH_TICKS);
    localparam logic [1:0]       IDX_LAST  = 2'(NUM_SENSORS - 1);

    state_t state, state_next;
    logic [1:0] idx;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc, width;
    logic [NUM_SENSORS-1:0] sync1, sync2, prev;
    logic tick, restart, rise, fall, done, done_to, adv;

    us_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .fpgaclk(fpgaclk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    // Edges come from the synchronized echo of the active sensor only; prev is
    // always tracked, so an echo already high on WAIT_RISE entry yields no rise.
    assign rise    = sync2[idx] & ~prev[idx];
    assign fall    = ~sync2[idx] & prev[idx];
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
    assign trigger = (state == TRIG) ? NUM_SENSORS'(1) << idx : '0;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        restart    = 1'b0;
        done       = 1'b0;
        done_to    = 1'b0;
        adv        = 1'b0;
        width      = cnt;
        case (state)
            IDLE: if (en) begin
                state_next = TRIG;
                cnt_next   = '0;
                restart    = 1'b1;
            end
            TRIG: if (!en) state_next = IDLE;
            else if (tick) begin
                cnt_next = cnt_inc;
                if (cnt == TRIG_LAST) begin
                    state_next = WAIT_RISE;
                    cnt_next   = '0;
                end
            end
            WAIT_RISE: if (!en) state_next = IDLE;
            else if (rise) begin
                // Realign the tick grid to the echo rise so the width is exact.
                state_next = MEASURE;
                cnt_next   = '0;
                restart    = 1'b1;
            end else if (tick) begin
                cnt_next = cnt_inc;
                if (cnt == TO_LAST) begin
                    state_next = GAP;
                    cnt_next   = '0;
                    done       = 1'b1;
                    done_to    = 1'b1;
                    width      = TO_VAL;
                end
            end
            MEASURE: if (!en) state_next = IDLE;
            else if (fall) begin
                // The tick coinciding with the fall still belongs to the pulse.
                state_next = GAP;
                cnt_next   = '0;
                done       = 1'b1;
                width      = tick ? cnt_inc : cnt;
            end else if (tick) begin
                cnt_next = cnt_inc;
                if (cnt == TO_LAST) begin
                    state_next = GAP;
                    cnt_next   = '0;
                    done       = 1'b1;
                    done_to    = 1'b1;
                    width      = TO_VAL;
                end
            end
            GAP: if (tick) begin
                cnt_next = cnt_inc;
                if (cnt == GAP_LAST) begin
                    state_next = en ? TRIG : IDLE;
                    cnt_next   = '0;
                    restart    = en;
                    adv        = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge fpgaclk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            sync1        <= '0;
            sync2        <= '0;
            prev         <= '0;
            led          <= '0;
            dist_us      <= '0;
            meas_valid   <= 1'b0;
            meas_idx     <= '0;
            meas_timeout <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            sync1      <= echo;
            sync2      <= sync1;
            prev       <= sync2;
            meas_valid <= done;
            if (adv) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (done) begin
                meas_idx                    <= idx;
                meas_timeout                <= done_to;
                dist_us[idx*CNT_W +: CNT_W] <= width;
                led[idx]                    <= !done_to && (width < THRESH);
            end
        end
    end
endmodule
